fifo_pkt_reg: RTL and testbench
===============================

Name: fifo_pkt_reg

Overview:
- Register-array FIFO with packet commit/discard, the next generation of the sniffer's register FIFO.
- Written words stay invisible to the reader until the writer commits the packet.
- A packet can be rolled back on a bad CRC or PID, or when it overflows the FIFO.
- Sits between the USB3300 ULPI receive path and the UART/readout stage, so only complete, good packets are forwarded.
- Adds: fill count, overflow/underflow pulses, and a first-word-fall-through (FWFT) mode.

Parameters:
- DATA_WIDTH, 8: word width in bits.
- DATA_DEPTH, 16: number of entries; power of 2, ≥4. AW = log2(DATA_DEPTH).
- ALMOST_FULL_VAL, 14: wr_almost_full threshold on speculative occupancy.
- ALMOST_EMPTY_VAL, 2: rd_almost_empty threshold on committed count.
- FWFT, 0: 0 = registered read (1-cycle latency); 1 = first-word-fall-through.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- wr_dv  in  1  write strobe.
- wr_DATA  in  DATA_WIDTH  write data.
- wr_commit  in  1  publish all uncommitted words, including any word written this cycle.
- wr_discard  in  1  drop all uncommitted words, including any word written this cycle.
- wr_full  out  1  speculative occupancy == DATA_DEPTH.
- wr_almost_full  out  1  speculative occupancy ≥ ALMOST_FULL_VAL.
- wr_overflow  out  1  one-cycle pulse: a write was rejected.
- rd_en  in  1  read/pop request.
- rd_DATA  out  DATA_WIDTH  read data.
- rd_valid  out  1  rd_DATA holds a popped word.
- rd_empty  out  1  committed count == 0.
- rd_almost_empty  out  1  committed count ≤ ALMOST_EMPTY_VAL.
- rd_count  out  AW+1  committed word count.
- rd_underflow  out  1  one-cycle pulse: rd_en while rd_empty.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Pointers: wr_ptr (speculative), cm_ptr (committed) and rd_ptr, each AW+1 bits. Natural wrap; the MSB distinguishes full from empty.
- Occupancy = wr_ptr − rd_ptr. rd_count = cm_ptr − rd_ptr, computed mod 2^(AW+1).
- All flags and rd_count are combinational from the registered pointers, so they reflect state after each edge.
- Write:
  - wr_dv && !wr_full → mem[wr_ptr] ← wr_DATA; wr_ptr++.
  - wr_dv && wr_full → word dropped; wr_overflow pulses next cycle; internal pkt_err is set.
- Full uses the pre-edge state. A read in the same cycle does not make room for a write.
- Commit: cm_ptr ← wr_ptr_next, i.e. including the same-cycle accepted write.
  - If pkt_err is set (or is being set this cycle), commit acts as a discard.
  - pkt_err clears on any commit or discard.
- Discard: wr_ptr ← cm_ptr; the same-cycle write is also dropped.
- wr_commit && wr_discard in the same cycle → discard wins.
- Commit or discard with no pending words → no-op; pkt_err still clears.
- Read, FWFT=0:
  - rd_en && !rd_empty → rd_DATA ← mem[rd_ptr]; rd_ptr++; rd_valid=1 on the next cycle only.
  - rd_DATA holds its last value otherwise.
- Read, FWFT=1:
  - rd_DATA = mem[rd_ptr] combinationally; rd_valid = !rd_empty.
  - rd_en && !rd_empty pops.
- rd_en && rd_empty → ignored; rd_underflow pulses next cycle. Uses the pre-edge state: a commit in the same cycle does not satisfy the read.
- Simultaneous write and read when neither full nor empty: both proceed; occupancy is unchanged.
- Reset (asynchronous, including mid-packet):
  - All pointers 0 and pkt_err 0; all uncommitted and committed data lost.
  - Outputs: rd_DATA 0, rd_valid 0, rd_empty 1, rd_almost_empty 1, rd_count 0.
  - Outputs: wr_full 0, wr_almost_full 0, wr_overflow 0, rd_underflow 0.
- Memory contents are not reset.

Test Plan (DATA_WIDTH=4, DATA_DEPTH=8, ALMOST_FULL_VAL=6, ALMOST_EMPTY_VAL=2, FWFT=0 unless stated):
1. Commit visibility: write 8,9,A without commit → rd_empty=1, rd_count=0. Pulse wr_commit → rd_count=3, rd_empty=0, rd_almost_empty=0.
2. Discard and read order: write 1,2 then wr_discard → rd_count stays 3. rd_en for 3 cycles → rd_DATA 8,9,A, each with rd_valid one cycle after its rd_en. Then rd_empty=1 and rd_almost_empty=1.
3. Full and overflow: write 0..7 with commit on the last word → wr_almost_full rises after the 6th write; wr_full=1 after the 8th. A 9th write of F → wr_overflow pulses once. Read 8 words → 0..7; F is never seen.
4. Overflowed packet: commit 6 words, write 3 more (3rd overflows), then wr_commit → rd_count=6, occupancy back to 6. A later packet of 1 word commits normally → rd_count=7.
5. Boundaries: rd_en while empty → rd_underflow pulse, rd_valid=0, rd_count=0. From empty, write+commit and rd_en in the same cycle → read ignored, rd_count=1. wr_commit && wr_discard together → discard wins.
6. FWFT=1 and reset: write and commit C → rd_DATA=C, rd_valid=1 with no rd_en; rd_en pops → rd_valid=0. Assert rst low mid-packet → all outputs at reset values immediately, rd_count=0.

Source files
------------

// File: rtl/fifo_pkt_reg.sv
// Register-array FIFO with packet commit/discard: written words stay hidden from
// the reader until the packet is committed; rejected or bad packets roll back.
module fifo_pkt_reg #(
  parameter int DATA_WIDTH       = 8,
  parameter int DATA_DEPTH       = 16,
  parameter int ALMOST_FULL_VAL  = 14,
  parameter int ALMOST_EMPTY_VAL = 2,
  parameter int FWFT             = 0,
  localparam int AW              = $clog2(DATA_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_dv,
  input  logic [DATA_WIDTH-1:0] wr_DATA,
  input  logic                  wr_commit,
  input  logic                  wr_discard,
  output logic                  wr_full,
  output logic                  wr_almost_full,
  output logic                  wr_overflow,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_DATA,
  output logic                  rd_valid,
  output logic                  rd_empty,
  output logic                  rd_almost_empty,
  output logic [AW:0]           rd_count,
  output logic                  rd_underflow
);

  localparam logic [AW:0] DEPTH_P = (AW+1)'(DATA_DEPTH);
  localparam logic [AW:0] AF_P    = (AW+1)'(ALMOST_FULL_VAL);
  localparam logic [AW:0] AE_P    = (AW+1)'(ALMOST_EMPTY_VAL);

  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] cm_ptr_q, cm_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        pkt_err_q, pkt_err_d;
  logic        overflow_q, underflow_q;

  logic [AW:0] occupancy;
  logic [AW:0] wr_ptr_inc;
  logic        wr_accept, wr_reject, rd_accept;
  logic        discard_eff, commit_eff;

  assign occupancy       = wr_ptr_q - rd_ptr_q;
  assign rd_count        = cm_ptr_q - rd_ptr_q;
  assign wr_full         = (occupancy == DEPTH_P);
  assign wr_almost_full  = (occupancy >= AF_P);
  assign rd_empty        = (rd_count == '0);
  assign rd_almost_empty = (rd_count <= AE_P);
  assign wr_overflow     = overflow_q;
  assign rd_underflow    = underflow_q;

  assign wr_accept  = wr_dv && !wr_full;
  assign wr_reject  = wr_dv && wr_full;
  assign rd_accept  = rd_en && !rd_empty;
  assign wr_ptr_inc = wr_ptr_q + {{AW{1'b0}}, wr_accept};

  // A commit on a packet that lost a word (now or earlier) is turned into a discard.
  assign discard_eff = wr_discard || (wr_commit && (pkt_err_q || wr_reject));
  assign commit_eff  = wr_commit && !discard_eff;

  always_comb begin
    wr_ptr_d  = discard_eff ? cm_ptr_q : wr_ptr_inc;
    cm_ptr_d  = commit_eff ? wr_ptr_inc : cm_ptr_q;
    rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, rd_accept};
    pkt_err_d = (wr_commit || wr_discard) ? 1'b0 : (pkt_err_q || wr_reject);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      cm_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pkt_err_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      cm_ptr_q    <= cm_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pkt_err_q   <= pkt_err_d;
      overflow_q  <= wr_reject;
      underflow_q <= rd_en && rd_empty;
    end
  end

  // The slot at wr_ptr is never unread data while not full, so a write that is
  // discarded in the same cycle can still land in the array harmlessly.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr_q[AW-1:0]] <= wr_DATA;
  end

  if (FWFT != 0) begin : g_fwft
    assign rd_DATA  = rd_empty ? '0 : mem[rd_ptr_q[AW-1:0]];
    assign rd_valid = !rd_empty;
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_accept;
        if (rd_accept) rd_data_q <= mem[rd_ptr_q[AW-1:0]];
      end
    end

    assign rd_DATA  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_fifo_pkt_reg.sv
// Bench for fifo_pkt_reg: a registered-read instance checked through a read-data
// scoreboard plus flag checks, and a FWFT instance for fall-through and reset.
module tb_fifo_pkt_reg;

  localparam int DW = 4;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          wr_dv = 0, wr_commit = 0, wr_discard = 0, rd_en = 0;
  logic [DW-1:0] wr_DATA = '0;
  logic          wr_full, wr_almost_full, wr_overflow;
  logic [DW-1:0] rd_DATA;
  logic          rd_valid, rd_empty, rd_almost_empty, rd_underflow;
  logic [AW:0]   rd_count;

  logic          f_wr_dv = 0, f_wr_commit = 0, f_wr_discard = 0, f_rd_en = 0;
  logic [DW-1:0] f_wr_DATA = '0;
  logic          f_wr_full, f_wr_almost_full, f_wr_overflow;
  logic [DW-1:0] f_rd_DATA;
  logic          f_rd_valid, f_rd_empty, f_rd_almost_empty, f_rd_underflow;
  logic [AW:0]   f_rd_count;

  fifo_pkt_reg #(.DATA_WIDTH(DW), .DATA_DEPTH(8), .ALMOST_FULL_VAL(6),
                 .ALMOST_EMPTY_VAL(2), .FWFT(0)) dut (
    .clk(clk), .rst(rst), .wr_dv(wr_dv), .wr_DATA(wr_DATA),
    .wr_commit(wr_commit), .wr_discard(wr_discard), .wr_full(wr_full),
    .wr_almost_full(wr_almost_full), .wr_overflow(wr_overflow), .rd_en(rd_en),
    .rd_DATA(rd_DATA), .rd_valid(rd_valid), .rd_empty(rd_empty),
    .rd_almost_empty(rd_almost_empty), .rd_count(rd_count),
    .rd_underflow(rd_underflow));

  fifo_pkt_reg #(.DATA_WIDTH(DW), .DATA_DEPTH(8), .ALMOST_FULL_VAL(6),
                 .ALMOST_EMPTY_VAL(2), .FWFT(1)) dut_f (
    .clk(clk), .rst(rst), .wr_dv(f_wr_dv), .wr_DATA(f_wr_DATA),
    .wr_commit(f_wr_commit), .wr_discard(f_wr_discard), .wr_full(f_wr_full),
    .wr_almost_full(f_wr_almost_full), .wr_overflow(f_wr_overflow), .rd_en(f_rd_en),
    .rd_DATA(f_rd_DATA), .rd_valid(f_rd_valid), .rd_empty(f_rd_empty),
    .rd_almost_empty(f_rd_almost_empty), .rd_count(f_rd_count),
    .rd_underflow(f_rd_underflow));

  int checks = 0;
  int errors = 0;
  int ovf_seen = 0;
  int exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every presented word must match the oldest expected one.
  always @(negedge clk) begin
    if (rst && wr_overflow) ovf_seen++;
    if (rst && rd_valid) begin
      if (exp_q.size() == 0) chk("rd_unexpected_word", 1, 0);
      else chk("rd_data", int'(rd_DATA), exp_q.pop_front());
    end
  end

  // One clock with the given inputs on the registered-read instance.
  task automatic step(input logic dv, input int d, input logic cm, input logic ds,
                      input logic rd, input int exp_rd);
    wr_dv = dv; wr_DATA = DW'(d); wr_commit = cm; wr_discard = ds; rd_en = rd;
    if (exp_rd >= 0) exp_q.push_back(exp_rd);
    @(posedge clk); #1;
    wr_dv = 0; wr_commit = 0; wr_discard = 0; rd_en = 0;
  endtask

  task automatic fstep(input logic dv, input int d, input logic cm, input logic rd);
    f_wr_dv = dv; f_wr_DATA = DW'(d); f_wr_commit = cm; f_rd_en = rd;
    @(posedge clk); #1;
    f_wr_dv = 0; f_wr_commit = 0; f_rd_en = 0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_rd_DATA", int'(rd_DATA), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_rd_empty", int'(rd_empty), 1);
    chk("rst_rd_almost_empty", int'(rd_almost_empty), 1);
    chk("rst_rd_count", int'(rd_count), 0);
    chk("rst_wr_full", int'(wr_full), 0);
    chk("rst_wr_almost_full", int'(wr_almost_full), 0);
    chk("rst_wr_overflow", int'(wr_overflow), 0);
    chk("rst_rd_underflow", int'(rd_underflow), 0);
    chk("rst_f_rd_DATA", int'(f_rd_DATA), 0);
    chk("rst_f_rd_valid", int'(f_rd_valid), 0);
    chk("rst_f_rd_count", int'(f_rd_count), 0);
    chk("rst_f_rd_empty", int'(f_rd_empty), 1);
    chk("rst_f_wr_full", int'(f_wr_full), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk_reset_outputs();
    rst = 1'b1;
    @(posedge clk); #1;

    // Commit visibility
    step(1, 8, 0, 0, 0, -1);
    step(1, 9, 0, 0, 0, -1);
    step(1, 10, 0, 0, 0, -1);
    chk("t1_empty_before_commit", int'(rd_empty), 1);
    chk("t1_count_before_commit", int'(rd_count), 0);
    step(0, 0, 1, 0, 0, -1);
    chk("t1_count", int'(rd_count), 3);
    chk("t1_empty", int'(rd_empty), 0);
    chk("t1_almost_empty", int'(rd_almost_empty), 0);

    // Discard then in-order read
    step(1, 1, 0, 0, 0, -1);
    step(1, 2, 0, 0, 0, -1);
    step(0, 0, 0, 1, 0, -1);
    chk("t2_count_after_discard", int'(rd_count), 3);
    step(0, 0, 0, 0, 1, 8);
    step(0, 0, 0, 0, 1, 9);
    step(0, 0, 0, 0, 1, 10);
    step(0, 0, 0, 0, 0, -1);
    chk("t2_empty", int'(rd_empty), 1);
    chk("t2_almost_empty", int'(rd_almost_empty), 1);

    // Full and overflow
    for (int i = 0; i < 8; i++) begin
      step(1, i, (i == 7), 0, 0, -1);
      if (i == 4) chk("t3_af_after5", int'(wr_almost_full), 0);
      if (i == 5) chk("t3_af_after6", int'(wr_almost_full), 1);
      if (i == 6) chk("t3_full_after7", int'(wr_full), 0);
    end
    chk("t3_full", int'(wr_full), 1);
    chk("t3_count", int'(rd_count), 8);
    step(1, 15, 0, 0, 0, -1);
    chk("t3_overflow_pulse", int'(wr_overflow), 1);
    step(0, 0, 0, 0, 0, -1);
    chk("t3_overflow_cleared", int'(wr_overflow), 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1, i);
    // No-op discard clears the error left by the rejected word
    step(0, 0, 0, 1, 0, -1);
    chk("t3_noop_discard_count", int'(rd_count), 0);

    // Overflowed packet rolls back on commit
    for (int i = 1; i <= 6; i++) step(1, i, (i == 6), 0, 0, -1);
    chk("t4_count6", int'(rd_count), 6);
    step(1, 7, 0, 0, 0, -1);
    step(1, 8, 0, 0, 0, -1);
    step(1, 9, 0, 0, 0, -1);
    chk("t4_overflow_pulse", int'(wr_overflow), 1);
    step(0, 0, 1, 0, 0, -1);
    chk("t4_count_after_bad_commit", int'(rd_count), 6);
    chk("t4_full_after_rollback", int'(wr_full), 0);
    chk("t4_af_after_rollback", int'(wr_almost_full), 1);
    step(1, 11, 1, 0, 0, -1);
    chk("t4_count7", int'(rd_count), 7);
    for (int i = 1; i <= 6; i++) step(0, 0, 0, 0, 1, i);
    step(0, 0, 0, 0, 1, 11);
    step(0, 0, 0, 0, 0, -1);

    // Boundaries
    step(0, 0, 0, 0, 1, -1);
    chk("t5_underflow_pulse", int'(rd_underflow), 1);
    chk("t5_valid_on_underflow", int'(rd_valid), 0);
    chk("t5_count0", int'(rd_count), 0);
    step(1, 5, 1, 0, 1, -1);
    chk("t5_same_cycle_read_ignored", int'(rd_count), 1);
    chk("t5_same_cycle_underflow", int'(rd_underflow), 1);
    chk("t5_no_valid_same_cycle", int'(rd_valid), 0);
    step(1, 6, 1, 1, 0, -1);
    chk("t5_discard_wins", int'(rd_count), 1);
    step(1, 7, 1, 0, 1, 5);
    chk("t5_wr_rd_count", int'(rd_count), 1);
    step(0, 0, 0, 0, 1, 7);
    step(0, 0, 0, 0, 0, -1);
    chk("t5_final_empty", int'(rd_empty), 1);

    // FWFT instance, then reset mid-packet
    fstep(1, 12, 1, 0);
    chk("t6_fwft_data", int'(f_rd_DATA), 12);
    chk("t6_fwft_valid", int'(f_rd_valid), 1);
    fstep(0, 0, 0, 1);
    chk("t6_fwft_valid_after_pop", int'(f_rd_valid), 0);
    fstep(1, 3, 1, 0);
    fstep(1, 4, 0, 0);
    step(1, 13, 1, 0, 0, -1);
    step(1, 14, 0, 0, 0, -1);
    chk("t6_pre_reset_count", int'(rd_count), 1);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_outputs();
    #3;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_count_after_release", int'(f_rd_count), 0);

    step(0, 0, 0, 0, 0, -1);
    chk("sb_queue_drained", exp_q.size(), 0);
    chk("overflow_pulses", ovf_seen, 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
